bsg_manycore_bp_link_scheduler: RTL and testbench
=================================================

// Module: bsg_manycore_bp_link_scheduler
//
// PURPOSE
//  Shares the four BlackParrot-side manycore request links (one per mesh router) between the
//  single BP request stream. It spreads packets over the links round-robin, gated by per-link
//  credits that cap outstanding requests. It also provides a fence: stop issuing, drain all
//  outstanding credits, then pulse done. Sits between the BP endpoint and the router proc ports.
//
// PARAMETERS
//  num_links_p    4    number of router links served (>=2)
//  pkt_width_p    128  manycore request packet width, bits
//  max_credits_p  8    max outstanding requests per link (>=1)
//  (local) credit_width_lp = $clog2(max_credits_p+1); lg_links_lp = $clog2(num_links_p)
//
// PORTS
//  clk_i           in   1                        clock
//  reset_n_i       in   1                        asynchronous reset, active-low
//  pkt_i           in   pkt_width_p              incoming request packet
//  v_i             in   1                        pkt_i valid
//  ready_and_o     out  1                        pkt_i accepted when v_i & ready_and_o
//  pkt_o           out  num_links_p*pkt_width_p  per-link packet (all lanes carry pkt_i)
//  v_o             out  num_links_p              per-link valid, at most one hot
//  ready_and_i     in   num_links_p              per-link ready
//  credit_return_i in   num_links_p              per-link one-cycle credit return pulse
//  fence_v_i       in   1                        fence request pulse
//  fence_done_o    out  1                        one-cycle pulse: fence complete
//  credit_err_o    out  1                        sticky: credit returned on a full link
//
// BEHAVIOUR
//  Async reset (reset_n_i=0): avail[l]=max_credits_p, rr_ptr=0, lock=0, state=RUN, all outputs 0.
//  States: RUN, DRAIN, DONE.
//  Eligibility: link l eligible iff avail[l]!=0. Readiness is NOT used for selection.
//  Grant: if lock=0, grant = first eligible link scanning rr_ptr, rr_ptr+1, ... (mod num_links_p);
//   if lock=1, grant = locked_id.
//  v_o[grant] = v_i & (lock | (state==RUN & any eligible)); other v_o bits 0.
//  ready_and_o = ready_and_i[grant] & v_o[grant] (pure pass of the granted handshake).
//  Lock: v_o[g]=1 & ready_and_i[g]=0 -> lock<=1, locked_id<=g; cleared on the handshake.
//   While locked, v_o stays on the same link; upstream must hold v_i/pkt_i (ready_and protocol).
//  Handshake on link g: avail[g]-=1; rr_ptr<=(g+1) mod num_links_p; lock<=0. Zero added latency.
//  Credit return: credit_return_i[l] -> avail[l]+=1. Same-cycle send+return on l: avail unchanged.
//   Return while avail[l]==max_credits_p (no send that cycle): avail saturates, credit_err_o<=1
//   (sticky until reset).
//  All links exhausted: ready_and_o=0, v_o=0 (unless locked), no state change.
//  Fence: fence_v_i in RUN -> DRAIN next cycle. In DRAIN no new grants; a locked transfer
//   still completes. DRAIN -> DONE when lock=0 and avail[l]==max_credits_p for all l
//   (credits returned that cycle count). DONE: fence_done_o=1 for exactly one cycle, -> RUN.
//   A fence with nothing outstanding: RUN->DRAIN->DONE, fence_done_o two cycles after fence_v_i.
//   fence_v_i in DRAIN or DONE is ignored (no queuing). A handshake in the fence_v_i cycle
//   is allowed and must drain.
//  Reset mid-operation: all state returns to reset values immediately; in-flight credits are
//   forgotten (the system resets routers in the same domain).
//
// TESTING
//  1 Reset, v_i held, all ready, 4 packets -> v_o sequence 0001,0010,0100,1000; avail each 7.
//  2 max_credits_p=8, no returns, 32 sends -> 33rd: ready_and_o=0, v_o=0; one return on link 2
//    -> next grant link 2.
//  3 ready_and_i[1]=0 when link 1 granted, for 5 cycles -> v_o stays 0010 (lock), no rotation;
//    ready -> handshake, rr_ptr=2.
//  4 3 outstanding on link 0, fence_v_i -> ready_and_o=0; returns at cycles 4,6,9 ->
//    fence_done_o single pulse at cycle 10, then RUN resumes.
//  5 Same-cycle send and return on link 3 -> avail[3] unchanged; return with avail=max ->
//    credit_err_o=1 and stays 1.
//  6 reset_n_i low mid-lock and mid-DRAIN -> v_o=0, fence_done_o=0, avail=max asynchronously.

Source files
------------

// File: rtl/bsg_manycore_bp_link_scheduler.sv
// bsg_manycore_bp_link_scheduler: spreads one BP request stream over router links round-robin,
// gated by per-link credits, with a drain-all fence.
module bsg_manycore_bp_link_scheduler #(
    parameter int num_links_p   = 4,
    parameter int pkt_width_p   = 128,
    parameter int max_credits_p = 8
) (
    input  logic                               clk_i,
    input  logic                               reset_n_i,
    input  logic [pkt_width_p-1:0]             pkt_i,
    input  logic                               v_i,
    output logic                               ready_and_o,
    output logic [num_links_p*pkt_width_p-1:0] pkt_o,
    output logic [num_links_p-1:0]             v_o,
    input  logic [num_links_p-1:0]             ready_and_i,
    input  logic [num_links_p-1:0]             credit_return_i,
    input  logic                               fence_v_i,
    output logic                               fence_done_o,
    output logic                               credit_err_o
);
    localparam int credit_width_lp = $clog2(max_credits_p+1);
    localparam int lg_links_lp = $clog2(num_links_p);
    localparam logic [credit_width_lp-1:0] max_lp = credit_width_lp'(max_credits_p);
    localparam logic [lg_links_lp:0] links_lp = (lg_links_lp+1)'(num_links_p);

    typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
    state_e state, state_n;
    logic [credit_width_lp-1:0] avail [num_links_p];
    logic [credit_width_lp-1:0] avail_n [num_links_p];
    logic [lg_links_lp-1:0] rr_ptr, locked_id, grant, scan;
    logic [lg_links_lp:0] sum;
    logic [num_links_p-1:0] elig, send;
    logic lock, lock_n, send_v, all_full, err_n;

    for (genvar l = 0; l < num_links_p; l++) begin : g_elig
        assign elig[l] = avail[l] != '0;
    end

    // Highest offset is visited first so the lowest offset from rr_ptr wins.
    always_comb begin
        grant = '0;
        sum = '0;
        scan = '0;
        for (int i = num_links_p-1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr} + (lg_links_lp+1)'(i);
            scan = sum >= links_lp ? lg_links_lp'(sum - links_lp) : sum[lg_links_lp-1:0];
            if (elig[scan]) grant = scan;
        end
        if (lock) grant = locked_id;
    end

    // Outputs are forced low while reset is held, even with v_i asserted.
    assign send_v = reset_n_i & v_i & (lock | (state == RUN & |elig));
    assign v_o = num_links_p'(send_v) << grant;
    assign ready_and_o = send_v & ready_and_i[grant];
    assign send = v_o & {num_links_p{ready_and_o}};
    assign pkt_o = {num_links_p{pkt_i}};
    assign fence_done_o = state == DONE;
    assign lock_n = ready_and_o ? 1'b0 : (send_v | lock);

    always_comb begin
        err_n = credit_err_o;
        all_full = 1'b1;
        for (int l = 0; l < num_links_p; l++) begin
            avail_n[l] = avail[l];
            if (send[l] & ~credit_return_i[l])
                avail_n[l] = avail[l] - 1'b1;
            else if (credit_return_i[l] & ~send[l]) begin
                if (avail[l] == max_lp) err_n = 1'b1;
                else avail_n[l] = avail[l] + 1'b1;
            end
            all_full &= avail_n[l] == max_lp;
        end
    end

    always_comb begin
        state_n = state;
        if (state == RUN && fence_v_i) state_n = DRAIN;
        else if (state == DRAIN && !lock_n && all_full) state_n = DONE;
        else if (state == DONE) state_n = RUN;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= RUN;
            rr_ptr <= '0;
            lock <= 1'b0;
            locked_id <= '0;
            credit_err_o <= 1'b0;
            for (int l = 0; l < num_links_p; l++) avail[l] <= max_lp;
        end else begin
            state <= state_n;
            lock <= lock_n;
            credit_err_o <= err_n;
            if (send_v & ~ready_and_i[grant]) locked_id <= grant;
            if (ready_and_o) rr_ptr <= grant == lg_links_lp'(num_links_p-1) ? '0 : grant + 1'b1;
            for (int l = 0; l < num_links_p; l++) avail[l] <= avail_n[l];
        end
    end
endmodule

// File: tb/tb_bsg_manycore_bp_link_scheduler.sv
// tb_bsg_manycore_bp_link_scheduler: randomized and directed checks against an
// outstanding-count reference model of the link scheduler.
module tb_bsg_manycore_bp_link_scheduler;
    localparam int NL = 4;
    localparam int PW = 128;
    localparam int MC = 8;

    logic clk_i = 1'b0;
    logic reset_n_i;
    logic [PW-1:0] pkt_i;
    logic v_i;
    logic ready_and_o;
    logic [NL*PW-1:0] pkt_o;
    logic [NL-1:0] v_o, ready_and_i, credit_return_i;
    logic fence_v_i, fence_done_o, credit_err_o;

    int vec = 0;
    int mis = 0;

    // Model: outstanding requests per link, next link to try, pending lock, fence phase.
    int m_out [NL];
    int m_ptr, m_lid, m_mode;
    bit m_lock, m_err;

    bsg_manycore_bp_link_scheduler #(.num_links_p(NL), .pkt_width_p(PW), .max_credits_p(MC)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .pkt_i(pkt_i), .v_i(v_i), .ready_and_o(ready_and_o),
        .pkt_o(pkt_o), .v_o(v_o), .ready_and_i(ready_and_i), .credit_return_i(credit_return_i),
        .fence_v_i(fence_v_i), .fence_done_o(fence_done_o), .credit_err_o(credit_err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic void m_reset();
        for (int l = 0; l < NL; l++) m_out[l] = 0;
        m_ptr = 0; m_lid = 0; m_mode = 0; m_lock = 0; m_err = 0;
    endfunction

    function automatic int m_grant();
        if (m_lock) return m_lid;
        for (int k = 0; k < NL; k++) begin
            int l;
            l = (m_ptr + k) % NL;
            if (m_out[l] < MC) return l;
        end
        return -1;
    endfunction

    function automatic logic [NL+2:0] m_expect();
        int g;
        bit go;
        g = m_grant();
        go = reset_n_i && v_i && g >= 0 && (m_lock || m_mode == 0);
        return {go ? NL'(1) << g : NL'(0), go ? ready_and_i[g] : 1'b0, m_mode == 2, m_err};
    endfunction

    function automatic void m_update();
        int g;
        bit go, hs, sent, idle;
        if (!reset_n_i) return;
        g = m_grant();
        go = v_i && g >= 0 && (m_lock || m_mode == 0);
        hs = go ? ready_and_i[g] : 1'b0;
        for (int l = 0; l < NL; l++) begin
            sent = hs && g == l;
            if (sent && !credit_return_i[l]) m_out[l]++;
            else if (!sent && credit_return_i[l]) begin
                if (m_out[l] == 0) m_err = 1;
                else m_out[l]--;
            end
        end
        if (hs) begin m_lock = 0; m_ptr = (g + 1) % NL; end
        else if (go) begin m_lock = 1; m_lid = g; end
        idle = 1;
        for (int l = 0; l < NL; l++) if (m_out[l] != 0) idle = 0;
        if (m_mode == 0) m_mode = fence_v_i ? 1 : 0;
        else if (m_mode == 1) m_mode = (!m_lock && idle) ? 2 : 1;
        else m_mode = 0;
    endfunction

    task automatic idle_inputs();
        v_i = 0; pkt_i = '0; ready_and_i = '1; credit_return_i = '0; fence_v_i = 0;
    endtask

    task automatic tick();
        m_update();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_n_i = 0;
        m_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        reset_n_i = 1;
    endtask

    task automatic test_reset();
        logic [NL+2:0] got;
        reset_n_i = 0;
        m_reset();
        v_i = 1; ready_and_i = '1; credit_return_i = '1; fence_v_i = 1; pkt_i = '1;
        #1;
        got = {v_o, ready_and_o, fence_done_o, credit_err_o};
        vec++;
        if (got !== m_expect() || got !== '0) begin
            mis++; $display("FAIL reset_outputs got %b exp %b", got, m_expect());
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [NL+2:0] got;
        do_reset();
        v_i = 1; ready_and_i = '1;
        for (int k = 0; k < NL; k++) begin
            pkt_i = {$urandom, $urandom, $urandom, $urandom};
            #1;
            got = {v_o, ready_and_o, fence_done_o, credit_err_o};
            vec++;
            if (got !== m_expect() || v_o !== NL'(1) << k) begin
                mis++; $display("FAIL round_robin k%0d got %b exp %b", k, got, m_expect());
            end
            vec++;
            if (pkt_o !== {NL{pkt_i}}) begin
                mis++; $display("FAIL pkt_fanout k%0d got %h", k, pkt_o);
            end
            tick();
        end
    endtask

    task automatic test_exhaust();
        logic [NL+2:0] got;
        do_reset();
        v_i = 1; ready_and_i = '1;
        for (int k = 0; k <= NL * MC; k++) begin
            #1;
            got = {v_o, ready_and_o, fence_done_o, credit_err_o};
            vec++;
            if (got !== m_expect()) begin
                mis++; $display("FAIL exhaust k%0d got %b exp %b", k, got, m_expect());
            end
            tick();
        end
        vec++;
        if (v_o !== '0 || ready_and_o !== 1'b0) begin
            mis++; $display("FAIL exhaust_stall v_o %b rdy %b exp 0 0", v_o, ready_and_o);
        end
        v_i = 0; credit_return_i = 4'b0100;
        tick();
        v_i = 1; credit_return_i = '0;
        #1;
        vec++;
        if (v_o !== 4'b0100 || v_o !== m_expect() >> 3) begin
            mis++; $display("FAIL exhaust_return got %b exp 0100", v_o);
        end
        tick();
    endtask

    task automatic test_lock();
        logic [NL+2:0] got;
        do_reset();
        v_i = 1; ready_and_i = '1;
        tick();
        ready_and_i = 4'b1101;
        for (int k = 0; k < 5; k++) begin
            #1;
            got = {v_o, ready_and_o, fence_done_o, credit_err_o};
            vec++;
            if (got !== m_expect() || v_o !== 4'b0010 || ready_and_o !== 1'b0) begin
                mis++; $display("FAIL lock_hold k%0d got %b exp %b", k, got, m_expect());
            end
            tick();
        end
        ready_and_i = '1;
        #1;
        vec++;
        if (v_o !== 4'b0010 || ready_and_o !== 1'b1) begin
            mis++; $display("FAIL lock_release v_o %b rdy %b exp 0010 1", v_o, ready_and_o);
        end
        tick();
        #1;
        vec++;
        if (v_o !== 4'b0100) begin
            mis++; $display("FAIL lock_rotate got %b exp 0100", v_o);
        end
        tick();
    endtask

    task automatic test_fence();
        logic [NL+2:0] got;
        int g;
        do_reset();
        v_i = 1; ready_and_i = '1;
        for (int k = 0; k < 3 * NL; k++) begin
            g = m_grant();
            credit_return_i = g > 0 ? NL'(1) << g : '0;
            tick();
        end
        for (int k = 0; k <= 12; k++) begin
            v_i = k != 0;
            fence_v_i = k == 0;
            credit_return_i = (k == 4 || k == 6 || k == 9) ? 4'b0001 : 4'b0000;
            #1;
            got = {v_o, ready_and_o, fence_done_o, credit_err_o};
            vec++;
            if (got !== m_expect() || fence_done_o !== (k == 10) ||
                (k >= 1 && k <= 10 && ready_and_o !== 1'b0)) begin
                mis++; $display("FAIL fence k%0d got %b exp %b", k, got, m_expect());
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_credit_err();
        logic [NL+2:0] got;
        do_reset();
        v_i = 1; ready_and_i = '1;
        for (int k = 0; k < 9; k++) begin
            v_i = k < 4;
            credit_return_i = k == 3 ? 4'b1000 : k == 4 ? 4'b0001 : k == 5 ? 4'b1000 : 4'b0000;
            #1;
            got = {v_o, ready_and_o, fence_done_o, credit_err_o};
            vec++;
            if (got !== m_expect() || credit_err_o !== (k >= 6)) begin
                mis++; $display("FAIL credit_err k%0d got %b exp %b", k, got, m_expect());
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        logic [NL+2:0] got;
        do_reset();
        v_i = 1; ready_and_i = 4'b1110;
        tick();
        #2;
        reset_n_i = 0;
        m_reset();
        #1;
        got = {v_o, ready_and_o, fence_done_o, credit_err_o};
        vec++;
        if (got !== '0 || got !== m_expect()) begin
            mis++; $display("FAIL reset_mid_lock got %b exp 0", got);
        end
        @(negedge clk_i);
        reset_n_i = 1; ready_and_i = '1;
        tick();
        tick();
        v_i = 0; fence_v_i = 1;
        tick();
        fence_v_i = 0;
        tick();
        #2;
        reset_n_i = 0;
        m_reset();
        #1;
        got = {v_o, ready_and_o, fence_done_o, credit_err_o};
        vec++;
        if (got !== '0) begin
            mis++; $display("FAIL reset_mid_drain got %b exp 0", got);
        end
        @(negedge clk_i);
        reset_n_i = 1; fence_v_i = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            got = {v_o, ready_and_o, fence_done_o, credit_err_o};
            vec++;
            if (got !== m_expect() || fence_done_o !== (k == 2)) begin
                mis++; $display("FAIL reset_fence k%0d got %b exp %b", k, got, m_expect());
            end
            tick();
            fence_v_i = 0;
        end
    endtask

    task automatic test_random();
        logic [NL+2:0] got;
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if (!m_lock) begin
                v_i = $urandom_range(0, 3) != 0;
                pkt_i = {$urandom, $urandom, $urandom, $urandom};
            end
            for (int l = 0; l < NL; l++) begin
                ready_and_i[l] = $urandom_range(0, 9) < 7;
                credit_return_i[l] = m_out[l] > 0 && $urandom_range(0, 2) == 0;
            end
            fence_v_i = $urandom_range(0, 39) == 0;
            #1;
            got = {v_o, ready_and_o, fence_done_o, credit_err_o};
            vec++;
            if (got !== m_expect() || pkt_o !== {NL{pkt_i}}) begin
                mis++; $display("FAIL random k%0d got %b exp %b", k, got, m_expect());
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_round_robin();
        test_exhaust();
        test_lock();
        test_fence();
        test_credit_err();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
        $finish;
    end
endmodule
